// File: rtl/osc_pkg.sv
// Shared encodings for the scope capture controller: trigger modes and FSM states.
package osc_pkg;

   localparam logic [1:0] MODE_FREE   = 2'd0;
   localparam logic [1:0] MODE_NORM   = 2'd1;
   localparam logic [1:0] MODE_SINGLE = 2'd2;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_TRIG,
      CAPTURE,
      DONE
   } osc_state_e;

   // The reserved encoding behaves as a normal edge trigger.
   function automatic logic [1:0] mode_norm(input logic [1:0] m);
      return (m == 2'd3) ? MODE_NORM : m;
   endfunction

endpackage

// File: rtl/osc_chan_writer.sv
// One capture channel: decimation counter, column address, full flag and the
// registered write port towards that channel's VDU buffer.
module osc_chan_writer #(
   parameter int DATA_W = 9,
   parameter int DEPTH  = 640,
   parameter int ADDR_W = 10,
   parameter int DEC_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              start_i,
   input  logic              cap_i,
   input  logic [DATA_W-1:0] sample_i,
   input  logic [DEC_W-1:0]  decim_i,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [DATA_W-1:0] wr_data_o,
   output logic              full_o
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   logic [DEC_W-1:0]  dc_q, dc_d;
   logic [DEC_W-1:0]  decim_q, decim_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              full_q, full_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;

   always_comb begin
      dc_d      = dc_q;
      decim_d   = decim_q;
      addr_d    = addr_q;
      full_d    = full_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (clr_i) begin
         dc_d   = '0;
         addr_d = '0;
         full_d = 1'b0;
      end else if (start_i) begin
         // Triggering sample is column 0; it also counts as decimation phase 0.
         decim_d   = decim_i;
         wr_en_d   = 1'b1;
         wr_addr_d = '0;
         wr_data_d = sample_i;
         addr_d    = ADDR_W'(1);
         full_d    = 1'b0;
         dc_d      = (decim_i == '0) ? '0 : DEC_W'(1);
      end else if (cap_i) begin
         if (dc_q == '0 && !full_q) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = sample_i;
            if (addr_q == LAST) full_d = 1'b1;
            else                addr_d = addr_q + 1'b1;
         end
         dc_d = (dc_q == decim_q) ? '0 : dc_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dc_q      <= '0;
         decim_q   <= '0;
         addr_q    <= '0;
         full_q    <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         dc_q      <= dc_d;
         decim_q   <= decim_d;
         addr_q    <= addr_d;
         full_q    <= full_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign wr_en_o   = wr_en_q;
   assign wr_addr_o = wr_addr_q;
   assign wr_data_o = wr_data_q;
   assign full_o    = full_q;

endmodule

// File: rtl/osc_capture_ctrl.sv
// Multi-channel capture controller: trigger comparator and frame FSM, with one
// osc_chan_writer per channel filling a DEPTH-column display frame.
module osc_capture_ctrl
   import osc_pkg::*;
#(
   parameter int CHANNELS = 2,
   parameter int DATA_W   = 9,
   parameter int DEPTH    = 640,
   parameter int ADDR_W   = 10,
   parameter int DEC_W    = 4,
   parameter int TSEL_W   = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       sample_en_i,
   input  logic [CHANNELS*DATA_W-1:0] sample_data_i,
   input  logic [1:0]                 mode_i,
   input  logic [TSEL_W-1:0]          trig_ch_i,
   input  logic [DATA_W-1:0]          trig_level_i,
   input  logic                       trig_rising_i,
   input  logic [CHANNELS*DEC_W-1:0]  decim_i,
   input  logic                       arm_i,
   input  logic                       stop_i,
   output logic [CHANNELS-1:0]        wr_en_o,
   output logic [CHANNELS*ADDR_W-1:0] wr_addr_o,
   output logic [CHANNELS*DATA_W-1:0] wr_data_o,
   output logic                       frame_done_o,
   output logic                       busy_o,
   output logic                       triggered_o
);

   osc_state_e        state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic [DATA_W-1:0] prev_q, prev_d;
   logic              prev_valid_q, prev_valid_d;
   logic              frame_done_q, busy_q, triggered_q;

   logic [DATA_W-1:0]   trig_s;
   logic                rise_hit, fall_hit, trig_hit;
   logic                start, cap, clr;
   logic [CHANNELS-1:0] full;

   // Out-of-range selects fall back to channel 0.
   always_comb begin
      trig_s = sample_data_i[0 +: DATA_W];
      for (int c = 0; c < CHANNELS; c++)
         if (trig_ch_i == TSEL_W'(c)) trig_s = sample_data_i[c*DATA_W +: DATA_W];
   end

   assign rise_hit = prev_valid_q && (prev_q <  trig_level_i) && (trig_s >= trig_level_i);
   assign fall_hit = prev_valid_q && (prev_q >= trig_level_i) && (trig_s <  trig_level_i);
   assign trig_hit = (mode_q == MODE_FREE) || (trig_rising_i ? rise_hit : fall_hit);

   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      prev_d       = prev_q;
      prev_valid_d = prev_valid_q;
      start        = 1'b0;
      cap          = 1'b0;
      clr          = 1'b0;
      case (state_q)
         IDLE: begin
            clr          = 1'b1;
            prev_valid_d = 1'b0;
            if (mode_norm(mode_i) != MODE_SINGLE || arm_i) begin
               state_d = WAIT_TRIG;
               mode_d  = mode_norm(mode_i);
            end
         end
         WAIT_TRIG: begin
            if (sample_en_i) begin
               prev_d       = trig_s;
               prev_valid_d = 1'b1;
               if (trig_hit) begin
                  start   = 1'b1;
                  state_d = CAPTURE;
               end
            end
         end
         CAPTURE: begin
            if (&full) state_d = DONE;
            else       cap     = sample_en_i;
         end
         DONE: begin
            clr          = 1'b1;
            prev_valid_d = 1'b0;
            mode_d       = mode_norm(mode_i);
            state_d      = (mode_norm(mode_i) == MODE_SINGLE) ? IDLE : WAIT_TRIG;
         end
         default: state_d = IDLE;
      endcase
      // Abort overrides everything, including an arm or trigger in the same cycle.
      if (stop_i) begin
         state_d      = IDLE;
         start        = 1'b0;
         cap          = 1'b0;
         clr          = 1'b1;
         prev_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         mode_q       <= MODE_FREE;
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
         triggered_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         prev_q       <= prev_d;
         prev_valid_q <= prev_valid_d;
         frame_done_q <= (state_d == DONE);
         busy_q       <= (state_d == WAIT_TRIG) || (state_d == CAPTURE);
         triggered_q  <= (state_d == CAPTURE);
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      osc_chan_writer #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH),
         .ADDR_W (ADDR_W),
         .DEC_W  (DEC_W)
      ) u_wr (
         .clk       (clk),
         .rst       (rst),
         .clr_i     (clr),
         .start_i   (start),
         .cap_i     (cap),
         .sample_i  (sample_data_i[c*DATA_W +: DATA_W]),
         .decim_i   (decim_i[c*DEC_W +: DEC_W]),
         .wr_en_o   (wr_en_o[c]),
         .wr_addr_o (wr_addr_o[c*ADDR_W +: ADDR_W]),
         .wr_data_o (wr_data_o[c*DATA_W +: DATA_W]),
         .full_o    (full[c])
      );
   end

   assign frame_done_o = frame_done_q;
   assign busy_o       = busy_q;
   assign triggered_o  = triggered_q;

endmodule

// File: doc/osc_capture_ctrl.md
Name: osc_capture_ctrl

Overview:
Parametrised multi-channel sample-capture controller for the scope front end. It takes per-channel samples qualified by a sampling strobe and applies a trigger: free-run, normal edge, or single-shot. It then writes one display frame of DEPTH columns per channel into the VDU channel buffers. Each channel has its own decimation and its own write address. The whole block runs in a single clock domain; the sampling rate is set by strobes rather than by a separate sampling clock.

Parameters:
CHANNELS, 2, number of input channels (>=2)
DATA_W, 9, sample width in bits (unsigned)
DEPTH, 640, columns per frame
ADDR_W, 10, write address width; 2^ADDR_W >= DEPTH required
DEC_W, 4, per-channel decimation field width
TSEL_W, 1, trigger-channel select width; 2^TSEL_W >= CHANNELS

Ports:
clk  in  1  system clock
rst  in  1  reset
sample_en  in  1  one-cycle strobe; sample_data valid
sample_data  in  CHANNELS*DATA_W  packed samples, channel c at [c*DATA_W +: DATA_W]
mode  in  2  0 free-run, 1 normal trigger, 2 single-shot, 3 reserved (treated as 1)
trig_ch  in  TSEL_W  trigger source channel
trig_level  in  DATA_W  trigger threshold
trig_rising  in  1  1 rising slope, 0 falling slope
decim  in  CHANNELS*DEC_W  per-channel decimation; channel c writes every (decim_c+1)-th sample
arm  in  1  single-shot arm pulse
stop  in  1  abort pulse
wr_en  out  CHANNELS  per-channel write strobe to VDU buffer
wr_addr  out  CHANNELS*ADDR_W  per-channel column address
wr_data  out  CHANNELS*DATA_W  per-channel write data
frame_done  out  1  one-cycle pulse when the frame is complete
busy  out  1  high in WAIT_TRIG or CAPTURE
triggered  out  1  high in CAPTURE

Behaviour:
- Interface (decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE. wr_en=0, wr_addr=0, wr_data=0, frame_done=0, busy=0, triggered=0. Decimation and address counters are 0; prev_valid=0.
- All outputs are registered.
- Write latency: a sample_en accepted in cycle t produces wr_en/wr_addr/wr_data in cycle t+1. wr_en is one cycle wide.
- States:
  - IDLE: mode 0/1 goes to WAIT_TRIG next cycle. Mode 2 waits for arm; arm=1 goes to WAIT_TRIG. mode is sampled only in IDLE and DONE.
  - WAIT_TRIG: on sample_en, sample s of trig_ch is compared with prev; prev is then updated and prev_valid set.
    - Mode 0 triggers on the first sample_en.
    - Rising trigger: prev_valid && prev < trig_level && s >= trig_level.
    - Falling trigger: prev_valid && prev >= trig_level && s < trig_level.
    - On trigger, decim and trig settings are latched and the state goes to CAPTURE. The triggering sample is written at addr 0 on all channels.
  - CAPTURE: each channel c keeps counter dc_c.
    - On sample_en with dc_c==0 and the channel not full: write the sample at addr_c, then addr_c++.
    - dc_c <= (dc_c==decim_c) ? 0 : dc_c+1.
    - The channel is full after writing addr DEPTH-1. Further writes are suppressed and the address does not wrap.
    - When all channels are full, go to DONE.
  - DONE: one cycle. frame_done=1, asserted in the cycle after the final wr_en. Mode 0/1 goes to WAIT_TRIG with counters and prev_valid cleared. Mode 2 goes to IDLE; the frame is held until the next arm.
- arm outside IDLE is ignored. arm and stop together: stop wins.
- stop in any state: next state IDLE, counters cleared. A wr_en already registered in that cycle still completes; no further writes occur.
- sample_en and rst in the same cycle: rst wins.
- Changes to trig_level, trig_rising or trig_ch during WAIT_TRIG take effect on the next sample. Changes to decim during CAPTURE are ignored until the next trigger.
- Comparisons are unsigned, DATA_W bits. The address counter is ADDR_W bits and saturates at DEPTH-1.

Decomposition:
- Package osc_pkg: mode encodings (MODE_FREE, MODE_NORM, MODE_SINGLE) and the state enum (IDLE, WAIT_TRIG, CAPTURE, DONE).
- Sub-module osc_chan_writer: decimation counter, address counter, full flag and output register for one channel. It is instantiated CHANNELS times by generate.
- The trigger comparator and FSM stay in the top level.

Test Plan:
- Free-run, decim=0, ramp input: sample_en every 2 clk -> ch0/ch1 wr_addr 0..639, each write 1 cycle after its strobe; frame_done once after addr 639; the next frame restarts at addr 0.
- Rising trigger at level 256 on ch0, inputs 250, 255, 256, 300 -> no writes for 250 and 255; 256 is written at addr 0 on every channel; 300 is written at addr 1.
- Falling trigger at level 100, ch1 source, inputs 120, 100, 99 -> trigger on 99 (100 >= level, not below) -> 99 at addr 0.
- decim ch0=0, ch1=1 -> ch1 writes every 2nd sample; ch0 full after 640 samples; frame_done only after ch1's 640th write (sample 1279); no ch0 writes after addr 639.
- Single-shot: no writes before arm; arm -> one frame, frame_done, IDLE, busy=0; arm during CAPTURE ignored; second arm starts a new frame.
- stop, then rst mid-CAPTURE at addr 300 -> IDLE, all outputs return to reset values next cycle, no further wr_en.
